mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 15, maximum cycles to wait for mem_ack.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancel the current or pending fetch (branch taken).
- if_rdata  out  DATA_W  fetched word.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  fetch must hold the PC.
- dm_req  in  1  data-memory request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle data completion pulse.
- dm_stall  out  1  MEM stage must freeze the pipeline.
- mem_req  out  1  shared single-port memory request.
- mem_we  out  1  shared memory write enable.
- mem_addr  out  ADDR_W  shared memory address.
- mem_wdata  out  DATA_W  shared memory write data.
- mem_rdata  in  DATA_W  shared memory read data.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- timeout_err  out  1  one-cycle pulse on transaction timeout.

Function
REQ-003 FSM states SHALL be IDLE, SERVE_IF, SERVE_DM and DRAIN.
REQ-004 IDLE SHALL grant a request:
- Grant DM if only dm_req=1.
- Grant IF if only (if_req & ~if_flush)=1.
- If both are eligible, grant DM unless the previous grant was DM, in which case grant IF (alternation flag last_dm).
REQ-005 A grant SHALL register the requester's addr/we/wdata into the mem_* outputs and enter SERVE_x on the next edge.
REQ-006 In SERVE_x, mem_req SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL be held stable until mem_ack.
REQ-007 mem_ack in SERVE_x SHALL:
- register mem_rdata into x_rdata (dm_rdata is undefined-but-stable for writes; implementation holds the previous value);
- pulse x_valid for exactly one cycle;
- deassert mem_req;
- return to IDLE.
REQ-008 Minimum latency SHALL be: request seen in IDLE at cycle N, mem_req=1 at N+1, x_valid=1 at N+2 when mem_ack=1 at N+1.
REQ-009 The memory SHALL never see two back-to-back transactions without one IDLE cycle between them.
REQ-010 x_stall SHALL equal x_req & ~x_valid (combinational); if_stall SHALL be 0 while if_flush=1.
REQ-011 if_flush in SERVE_IF without mem_ack SHALL enter DRAIN; DRAIN SHALL keep mem_req=1 until mem_ack, discard the data, produce no if_valid, then go to IDLE.
REQ-012 if_flush coincident with mem_ack in SERVE_IF SHALL discard the data (no if_valid) and go to IDLE.
REQ-013 if_flush SHALL have no effect in SERVE_DM.
REQ-014 A timeout counter SHALL clear on entry to SERVE_x/DRAIN and increment each cycle without mem_ack.
REQ-015 When the counter reaches TIMEOUT, the block SHALL:
- deassert mem_req;
- pulse timeout_err;
- pulse x_valid with x_rdata=0 (no x_valid in DRAIN);
- go to IDLE.
REQ-016 mem_ack while in IDLE SHALL be ignored.
REQ-017 last_dm SHALL be updated only on a grant.

Reset
REQ-018 Asserting rst SHALL asynchronously return the FSM to IDLE, abandon any in-flight transaction, and set the following to 0: every output (including if_rdata and dm_rdata), last_dm, and the counter.
REQ-019 Release of rst SHALL allow the first grant at the first rising edge at which rst is low.

Structure
REQ-020 A shared package SHALL hold the state enum, the ADDR_W/DATA_W/TIMEOUT defaults and the requester-ID encoding (IF=0, DM=1).
REQ-021 The timeout counter SHALL be one sub-module, arb_timeout_ctr (clear, enable, expired), of width clog2(TIMEOUT+1).

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single fetch: if_req=1, if_addr=0x40, mem_ack one cycle after mem_req with rdata 0x1234ABCD -> if_valid at N+2 with if_rdata=0x1234ABCD, if_stall=1 through N+1.
- Simultaneous requests, repeated three times: if_req=dm_req=1 (dm_we=1, addr 0x100, wdata 0xCAFE) -> grant order DM, IF, DM; one IDLE cycle between mem_req pulses; mem_we=1 only on DM grants.
- Flush: SERVE_IF with mem_ack delayed 4 cycles, if_flush pulsed in cycle 2 -> DRAIN, no if_valid, mem_req held until ack, then IDLE.
- Timeout: dm_req read, mem_ack never asserted, TIMEOUT=15 -> timeout_err and dm_valid pulse 15 cycles after SERVE_DM entry, dm_rdata=0, mem_req=0.
- Reset mid-operation: rst asserted in SERVE_DM between clock edges -> all outputs 0 immediately; after release a pending if_req is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / data-memory port arbiter.
//   - arb_state_t : arbiter FSM states
//   - req_id_t    : requester identity (IF=0, DM=1)
//   - DEF_*       : default address/data widths and ack timeout
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2,
        DRAIN    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter that bounds how long the arbiter waits for mem_ack.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (transaction entry)
//   enable    - count this cycle (busy and no ack)
//   expired   - high in the last tolerated cycle; the arbiter gives up on
//               that edge, so the counter reaches TIMEOUT exactly as the
//               timeout is taken and the pulse lands TIMEOUT cycles after
//               entry.
module arb_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int          W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] MAX  = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != MAX)
            cnt <= cnt + W'(1);
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port (IF) and a data port (DM) onto one single-port
// memory. One transaction in flight at a time; every transaction is
// followed by at least one IDLE cycle. DM wins ties unless DM had the
// previous grant. A fetch flushed mid-flight is drained (memory still
// acked) and its data discarded. A missing ack is abandoned after TIMEOUT
// cycles with timeout_err and a zero-data completion.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   if_req/if_addr/if_flush        - fetch request, address, cancel
//   if_rdata/if_valid/if_stall     - fetch data, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata  - data request
//   dm_rdata/dm_valid/dm_stall     - load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack - memory side
//   timeout_err                    - one-cycle pulse on abandoned access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    arb_state_t        state, state_d;
    logic              last_dm, last_dm_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic              if_valid_d, dm_valid_d, timeout_err_d;
    logic              if_elig, grant;
    req_id_t           grant_id;
    logic              ctr_clear, ctr_enable, expired;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (expired)
    );

    // A flushed fetch is not a candidate for a grant.
    assign if_elig = if_req & ~if_flush;

    // Any non-IDLE state has a transaction outstanding on the memory.
    assign ctr_enable = (state != IDLE) & ~mem_ack;

    always_comb begin
        grant    = 1'b0;
        grant_id = REQ_IF;
        if (dm_req && (!if_elig || !last_dm)) begin
            grant    = 1'b1;
            grant_id = REQ_DM;
        end else if (if_elig) begin
            grant    = 1'b1;
            grant_id = REQ_IF;
        end
    end

    always_comb begin
        state_d       = state;
        last_dm_d     = last_dm;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        if_rdata_d    = if_rdata;
        dm_rdata_d    = dm_rdata;
        if_valid_d    = 1'b0;
        dm_valid_d    = 1'b0;
        timeout_err_d = 1'b0;
        ctr_clear     = 1'b0;

        case (state)
            IDLE: begin
                // mem_ack is ignored here: nothing is outstanding.
                if (grant) begin
                    ctr_clear = 1'b1;
                    mem_req_d = 1'b1;
                    last_dm_d = (grant_id == REQ_DM);
                    if (grant_id == REQ_DM) begin
                        state_d     = SERVE_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        state_d    = SERVE_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end

            SERVE_IF: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!if_flush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    // A fetch cancelled in its final cycle gets no completion.
                    if (!if_flush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end else if (if_flush) begin
                    // The memory has already seen the request, so it must
                    // still be held until acked; the data is then dropped.
                    state_d   = DRAIN;
                    ctr_clear = 1'b1;
                end
            end

            SERVE_DM: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    // Stores leave the last load value in place.
                    if (!mem_we)
                        dm_rdata_d = mem_rdata;
                end else if (expired) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    dm_valid_d    = 1'b1;
                    dm_rdata_d    = '0;
                    timeout_err_d = 1'b1;
                end
            end

            DRAIN: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (expired) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_dm     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_valid    <= 1'b0;
            dm_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            last_dm     <= last_dm_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            if_rdata    <= if_rdata_d;
            dm_rdata    <= dm_rdata_d;
            if_valid    <= if_valid_d;
            dm_valid    <= dm_valid_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Stalls are combinational so the requester sees release in the same
    // cycle as the valid pulse; held low during reset like every output.
    assign if_stall = ~rst & if_req & ~if_flush & ~if_valid;
    assign dm_stall = ~rst & dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default parameters, TIMEOUT=15).
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout_err(timeout_err)
    );

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_valid, dm_valid, timeout_err, if_stall, dm_stall} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {mem_req, mem_we, if_valid, dm_valid, timeout_err, if_stall, dm_stall});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: if=%h dm=%h want 0", if_rdata, dm_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: mem_req=%b want 0", mem_req);
        end
    endtask

    task automatic test_single_fetch;
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin
            failures++;
            $display("FAIL fetch_stall_n: got %b want 1", if_stall);
        end
        @(negedge clk);  // N+1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b want 1/00000040/0", mem_req, mem_addr, mem_we);
        end
        checks++;
        if (if_stall !== 1'b1 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_stall_n1: stall=%b valid=%b want 1/0", if_stall, if_valid);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234ABCD;
        @(negedge clk);  // N+2
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL fetch_done: valid=%b rdata=%h want 1/1234abcd", if_valid, if_rdata);
        end
        checks++;
        if (mem_req !== 1'b0 || if_stall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_release: req=%b stall=%b want 0/0", mem_req, if_stall);
        end
        // ack left high in IDLE with no request must be ignored
        if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL idle_ack_ignored: valid=%b req=%b rdata=%h want 0/0/1234abcd",
                     if_valid, mem_req, if_rdata);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_alternation;
        logic [5:0] e_req, e_ifv, e_dmv;
        e_req = 6'b010101;  // bit k = cycle k after the first grant
        e_ifv = 6'b001000;
        e_dmv = 6'b100010;
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFE;
        mem_rdata = 32'h77;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== e_req[k] || if_valid !== e_ifv[k] || dm_valid !== e_dmv[k]) begin
                failures++;
                $display("FAIL alt_cycle%0d: req/ifv/dmv=%b%b%b want %b%b%b", k,
                         mem_req, if_valid, dm_valid, e_req[k], e_ifv[k], e_dmv[k]);
            end
            if (e_req[k]) begin
                checks++;
                if (mem_we !== (k != 2) || mem_addr !== ((k == 2) ? 32'h200 : 32'h100)) begin
                    failures++;
                    $display("FAIL alt_grant%0d: we=%b addr=%h want %b/%h", k, mem_we, mem_addr,
                             (k != 2), ((k == 2) ? 32'h200 : 32'h100));
                end
                if (k != 2) begin
                    checks++;
                    if (mem_wdata !== 32'hCAFE) begin
                        failures++;
                        $display("FAIL alt_wdata%0d: got %h want 0000cafe", k, mem_wdata);
                    end
                end
            end
            if (k == 5) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            mem_ack = mem_req;
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h77) begin
            failures++;
            $display("FAIL alt_end: req=%b dm_rdata=%h if_rdata=%h want 0/0/77", mem_req, dm_rdata, if_rdata);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_flush;
        if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h5555;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (mem_req !== 1'b1 || if_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_hold%0d: req=%b valid=%b want 1/0", k, mem_req, if_valid);
                end
            end else begin
                checks++;
                if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h77 || timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_drop%0d: req=%b valid=%b rdata=%h err=%b want 0/0/77/0",
                             k, mem_req, if_valid, if_rdata, timeout_err);
                end
            end
            if (k == 2) begin
                if_flush = 1'b1;
                #1;
                checks++;
                if (if_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_stall: got %b want 0", if_stall);
                end
            end
            if (k == 3) begin
                if_flush = 1'b0; if_req = 1'b0;
            end
            if (k == 4) mem_ack = 1'b1;
            if (k == 5) mem_ack = 1'b0;
        end
    endtask

    task automatic test_dm_read;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300 || dm_stall !== 1'b1) begin
            failures++;
            $display("FAIL dm_read_issue: req=%b we=%b addr=%h stall=%b want 1/0/300/1",
                     mem_req, mem_we, mem_addr, dm_stall);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h0BADF00D || dm_stall !== 1'b0) begin
            failures++;
            $display("FAIL dm_read_done: valid=%b rdata=%h stall=%b want 1/0badf00d/0", dm_valid, dm_rdata, dm_stall);
        end
        dm_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h304;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 15) begin
                checks++;
                if ({mem_req, dm_valid, timeout_err} !== 3'b100) begin
                    failures++;
                    $display("FAIL tmo_wait%0d: req/valid/err=%b want 100", k, {mem_req, dm_valid, timeout_err});
                end
            end else begin
                checks++;
                if ({mem_req, dm_valid, timeout_err} !== 3'b011 || dm_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL tmo_fire: req/valid/err=%b rdata=%h want 011/0",
                             {mem_req, dm_valid, timeout_err}, dm_rdata);
                end
                dm_req = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_req, dm_valid, timeout_err} !== 3'b000) begin
            failures++;
            $display("FAIL tmo_after: req/valid/err=%b want 000", {mem_req, dm_valid, timeout_err});
        end
    endtask

    task automatic test_reset_mid;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h11;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h400) begin
            failures++;
            $display("FAIL rst_mid_serve: req=%b we=%b addr=%h want 1/1/400", mem_req, mem_we, mem_addr);
        end
        if_req = 1'b1; if_addr = 32'h500;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, if_valid, dm_valid, timeout_err, if_stall, dm_stall} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid_flags: got %b want 0000000",
                     {mem_req, mem_we, if_valid, dm_valid, timeout_err, if_stall, dm_stall});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_data: addr=%h wdata=%h if=%h dm=%h want 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_held: mem_req=%b want 0", mem_req);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_grant: req=%b addr=%h we=%b want 1/500/0", mem_req, mem_addr, mem_we);
        end
        mem_ack = 1'b1; mem_rdata = 32'h600D;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h600D) begin
            failures++;
            $display("FAIL rst_fetch_done: valid=%b rdata=%h want 1/600d", if_valid, if_rdata);
        end
        if_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_alternation;
        test_flush;
        test_dm_read;
        test_timeout;
        test_reset_mid;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
